// File: rtl/imm_extend_stage.sv
// Pipelined immediate extender with a 2-entry skid buffer.
// Holds already-extended values plus a sideband tag; InReady is registered.
module imm_extend_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [IN_W-1:0]  ExtAddr,
  input  logic [1:0]       ExtSel,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [OUT_W-1:0] ExtOut,
  output logic [TAG_W-1:0] OutTag
);

  if (OUT_W < IN_W + 2) begin : gBadWidth
    $error("imm_extend_stage: OUT_W must be at least IN_W+2");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e state;
  state_e nextState;

  logic [OUT_W-1:0] zeroExt;
  logic [OUT_W-1:0] signExt;
  logic [OUT_W-1:0] upperExt;
  logic [OUT_W-1:0] branchExt;
  logic [OUT_W-1:0] extVal;

  logic [OUT_W-1:0] mainVal;
  logic [TAG_W-1:0] mainTag;
  logic [OUT_W-1:0] skidVal;
  logic [TAG_W-1:0] skidTag;

  logic inReadyQ;
  logic accept;
  logic pop;
  logic loadMain;
  logic loadSkid;
  logic moveSkid;

  assign zeroExt   = {{(OUT_W-IN_W){1'b0}}, ExtAddr};
  assign signExt   = {{(OUT_W-IN_W){ExtAddr[IN_W-1]}}, ExtAddr};
  assign upperExt  = {ExtAddr, {(OUT_W-IN_W){1'b0}}};
  assign branchExt = {signExt[OUT_W-3:0], 2'b00};

  always_comb begin
    extVal = zeroExt;
    unique case (ExtSel)
      2'b00:   extVal = zeroExt;
      2'b01:   extVal = signExt;
      2'b10:   extVal = upperExt;
      2'b11:   extVal = branchExt;
      default: extVal = zeroExt;
    endcase
  end

  assign InReady  = inReadyQ;
  assign OutValid = (state != EMPTY);
  assign ExtOut   = mainVal;
  assign OutTag   = mainTag;

  assign accept = InValid & inReadyQ;
  assign pop    = OutValid & OutReady;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= EMPTY;
      inReadyQ <= 1'b1;
    end else begin
      state    <= nextState;
      inReadyQ <= (nextState != TWO);
    end
  end

  always_comb begin
    nextState = state;
    if (Flush) begin
      nextState = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) nextState = ONE;
        end
        ONE: begin
          if (accept && !pop)
            nextState = TWO;
          else if (!accept && pop)
            nextState = EMPTY;
        end
        TWO: begin
          if (pop) nextState = ONE;
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  // A flushed cycle never loads; any same-cycle accept is dropped.
  always_comb begin
    loadMain = 1'b0;
    loadSkid = 1'b0;
    moveSkid = 1'b0;
    if (!Flush) begin
      unique case (state)
        EMPTY: loadMain = accept;
        ONE: begin
          loadMain = accept & pop;
          loadSkid = accept & ~pop;
        end
        TWO:     moveSkid = pop;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      mainVal <= '0;
      mainTag <= '0;
      skidVal <= '0;
      skidTag <= '0;
    end else begin
      if (loadMain) begin
        mainVal <= extVal;
        mainTag <= InTag;
      end else if (moveSkid) begin
        mainVal <= skidVal;
        mainTag <= skidTag;
      end
      if (loadSkid) begin
        skidVal <= extVal;
        skidTag <= InTag;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Scoreboard bench for imm_extend_stage.
// Driver queues expected entries; a negedge monitor pops and compares.
module tb_imm_extend_stage;

  typedef struct packed {
    logic [31:0] val;
    logic [4:0]  tag;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Flush = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [15:0] ExtAddr = '0;
  logic [1:0]  ExtSel = '0;
  logic [4:0]  InTag = '0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] ExtOut;
  logic [4:0]  OutTag;

  logic        sValid = 1'b0;
  logic        sReady;
  logic [11:0] sAddr = '0;
  logic [1:0]  sSel = '0;
  logic [4:0]  sTag = '0;
  logic        sOutValid;
  logic [15:0] sOut;
  logic [4:0]  sOutTag;

  int nChecks = 0;
  int nPass = 0;
  int popCount = 0;
  exp_t expQ[$];

  always #5 CLK = ~CLK;

  imm_extend_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .CLK(CLK), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .ExtAddr(ExtAddr), .ExtSel(ExtSel), .InTag(InTag),
    .OutValid(OutValid), .OutReady(OutReady),
    .ExtOut(ExtOut), .OutTag(OutTag)
  );

  imm_extend_stage #(.IN_W(12), .OUT_W(16), .TAG_W(5)) dutS (
    .CLK(CLK), .Reset(Reset), .Flush(1'b0),
    .InValid(sValid), .InReady(sReady),
    .ExtAddr(sAddr), .ExtSel(sSel), .InTag(sTag),
    .OutValid(sOutValid), .OutReady(1'b1),
    .ExtOut(sOut), .OutTag(sOutTag)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    if (!Reset && OutValid && OutReady) begin
      popCount++;
      if (expQ.size() == 0) begin
        nChecks++;
        $display("FAIL unexpected_out: got %h tag %h expected none",
                 ExtOut, OutTag);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("out_val", ExtOut, e.val);
        check("out_tag", 32'(OutTag), 32'(e.tag));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [15:0] a, input logic [1:0] s,
                      input logic [4:0] t, input logic [31:0] e);
    int waitCnt;
    exp_t x;
    InValid = 1'b1;
    ExtAddr = a;
    ExtSel  = s;
    InTag   = t;
    waitCnt = 0;
    @(negedge CLK);
    while (!InReady && waitCnt < 20) begin
      waitCnt++;
      @(negedge CLK);
    end
    if (!InReady) begin
      nChecks++;
      $display("FAIL send_timeout: got InReady 0 expected 1");
    end else begin
      x.val = e;
      x.tag = t;
      expQ.push_back(x);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    InValid = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic sweep(input logic [1:0] s, input logic [15:0] e,
                       input string name);
    sValid = 1'b1;
    sAddr  = 12'h800;
    sSel   = s;
    sTag   = 5'(s);
    @(posedge CLK);
    #1;
    check(name, 32'(sOut), 32'(e));
  endtask

  initial begin
    int base;
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_inready", 32'(InReady), 32'd1);
    check("rst_extout", ExtOut, 32'd0);
    check("rst_outtag", 32'(OutTag), 32'd0);

    sweep(2'b01, 16'hF800, "sweep_sign");
    sweep(2'b10, 16'h8000, "sweep_upper");
    sweep(2'b11, 16'hE000, "sweep_branch");
    sValid = 1'b0;

    OutReady = 1'b1;
    send(16'hFFE0, 2'b00, 5'd1, 32'h0000FFE0);
    check("latency_valid", 32'(OutValid), 32'd1);
    check("latency_val", ExtOut, 32'h0000FFE0);
    send(16'hFFE0, 2'b01, 5'd2, 32'hFFFFFFE0);
    send(16'hFFE0, 2'b10, 5'd3, 32'hFFE00000);
    send(16'hFFE0, 2'b11, 5'd4, 32'hFFFFFF80);
    send(16'h0020, 2'b01, 5'd5, 32'h00000020);
    idle(2);

    base = popCount;
    for (int i = 0; i < 8; i++) begin
      send(16'(16'h8000 + i), 2'(i), 5'(i + 8),
           (i % 4 == 0) ? 32'(16'h8000 + i) :
           (i % 4 == 1) ? (32'hFFFF8000 + 32'(i)) :
           (i % 4 == 2) ? {16'(16'h8000 + i), 16'h0000} :
                          ((32'hFFFF8000 + 32'(i)) << 2));
      check("stream_inready", 32'(InReady), 32'd1);
    end
    InValid = 1'b0;
    @(negedge CLK);
    #1;
    check("stream_count", 32'(popCount - base), 32'd8);
    idle(1);

    OutReady = 1'b0;
    send(16'h1234, 2'b01, 5'd20, 32'h00001234);
    send(16'h8001, 2'b01, 5'd21, 32'hFFFF8001);
    InValid = 1'b0;
    check("bp_inready_low", 32'(InReady), 32'd0);
    check("bp_hold_a", ExtOut, 32'h00001234);
    @(posedge CLK);
    #1;
    check("bp_still_a", ExtOut, 32'h00001234);
    check("bp_still_tag", 32'(OutTag), 32'd20);
    OutReady = 1'b1;
    @(posedge CLK);
    #1;
    check("bp_inready_back", 32'(InReady), 32'd1);
    check("bp_now_b", ExtOut, 32'hFFFF8001);
    @(posedge CLK);
    #1;
    check("bp_drained", 32'(OutValid), 32'd0);

    OutReady = 1'b0;
    send(16'h0001, 2'b00, 5'd22, 32'h00000001);
    send(16'h0002, 2'b00, 5'd23, 32'h00000002);
    InValid = 1'b1;
    ExtAddr = 16'h0BAD;
    ExtSel  = 2'b00;
    InTag   = 5'd24;
    Flush   = 1'b1;
    @(posedge CLK);
    #1;
    Flush   = 1'b0;
    InValid = 1'b0;
    expQ.delete();
    check("flush_outvalid", 32'(OutValid), 32'd0);
    check("flush_inready", 32'(InReady), 32'd1);
    base = popCount;
    OutReady = 1'b1;
    idle(3);
    check("flush_no_output", 32'(popCount - base), 32'd0);
    send(16'h7FFF, 2'b11, 5'd25, 32'h0001FFFC);
    idle(2);

    OutReady = 1'b0;
    send(16'h4444, 2'b10, 5'd26, 32'h44440000);
    send(16'h5555, 2'b10, 5'd27, 32'h55550000);
    InValid = 1'b0;
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    expQ.delete();
    check("mrst_outvalid", 32'(OutValid), 32'd0);
    check("mrst_inready", 32'(InReady), 32'd1);
    check("mrst_extout", ExtOut, 32'd0);
    check("mrst_outtag", 32'(OutTag), 32'd0);
    OutReady = 1'b1;
    send(16'h8000, 2'b01, 5'd28, 32'hFFFF8000);
    idle(3);

    check("queue_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
